// File: rtl/i2c_init_sequencer_if.sv
// i2c_init_sequencer_if
// Bundles the sequencer's control, table-lookup and I2C-master request signals.
// The master modport is the sequencer's view. The slave modport is the view of
// the environment: the table ROM, the I2C master and the host control.
interface i2c_init_sequencer_if;
  logic       init_start;
  logic [7:0] tbl_idx;
  logic [7:0] tbl_reg;
  logic [7:0] tbl_data;
  logic       i2c_start;
  logic       i2c_done;
  logic       i2c_error;
  logic [6:0] i2c_slave_addr;
  logic [7:0] i2c_reg_addr;
  logic       i2c_rw;
  logic [7:0] i2c_wdata;
  logic [7:0] i2c_rdata;
  logic       busy;
  logic       init_done;
  logic       init_fail;
  logic [7:0] fail_idx;

  modport master (
    input  init_start, tbl_reg, tbl_data, i2c_done, i2c_error, i2c_rdata,
    output tbl_idx, i2c_start, i2c_slave_addr, i2c_reg_addr, i2c_rw, i2c_wdata,
           busy, init_done, init_fail, fail_idx
  );

  modport slave (
    output init_start, tbl_reg, tbl_data, i2c_done, i2c_error, i2c_rdata,
    input  tbl_idx, i2c_start, i2c_slave_addr, i2c_reg_addr, i2c_rw, i2c_wdata,
           busy, init_done, init_fail, fail_idx
  );
endinterface

// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer
// Walks a combinational register table after a power-up wait. Each entry is
// either a register write issued to an I2C master, or a millisecond delay
// (reg == 8'hFF, data = ms). A NACK retries the entry up to MAX_RETRIES times
// before the sequence aborts.
// Optional feature: define I2C_INIT_READBACK_EN to read back every written
// register. A read-back NACK or a data mismatch retries the entry from its write.
module i2c_init_sequencer #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter logic [6:0]  SLAVE_ADDR  = 7'h39,
  parameter int unsigned NUM_ENTRIES = 64,
  parameter int unsigned STARTUP_MS  = 200,
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  i2c_init_sequencer_if.master bus
);

  // A clock slower than 1 kHz still gets a one-cycle "ms" rather than a zero divisor.
  localparam int unsigned TICK_CYC     = (CLK_FREQ_HZ >= 1000) ? CLK_FREQ_HZ / 1000 : 1;
  localparam logic [31:0] TICK_LAST    = 32'(TICK_CYC - 1);
  localparam logic [15:0] STARTUP_LAST = (STARTUP_MS == 0) ? 16'd0 : 16'(STARTUP_MS - 1);
  localparam logic [7:0]  LAST_IDX     = 8'(NUM_ENTRIES - 1);
  localparam logic [7:0]  RETRY_MAX    = 8'(MAX_RETRIES);

`ifdef I2C_INIT_READBACK_EN
  typedef enum logic [3:0] {
    PWR_WAIT, FETCH, ISSUE, WAIT_WR, ISSUE_RD, WAIT_RD, DELAY, NEXT, DONE, FAIL
  } state_t;
`else
  typedef enum logic [3:0] {
    PWR_WAIT, FETCH, ISSUE, WAIT_WR, DELAY, NEXT, DONE, FAIL
  } state_t;
`endif

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_idx;
  logic [7:0]  r_reg;
  logic [7:0]  r_data;
  logic [7:0]  r_retry;
  logic [31:0] r_cyc;
  logic [15:0] r_ms;
  logic [7:0]  r_fail_idx;

  logic w_tick;
  logic w_start_hit;
  logic w_delay_hit;
  logic w_can_retry;
  logic w_latch;
  logic w_retry_inc;
  logic w_cnt_restart;
  logic w_idx_inc;
  logic w_idx_clr;
  logic w_set_fail;
  logic w_clr_fail;

  assign w_tick      = (r_cyc == TICK_LAST);
  assign w_start_hit = w_tick && (r_ms == STARTUP_LAST);
  assign w_delay_hit = w_tick && (r_ms == ({8'd0, r_data} - 16'd1));
  assign w_can_retry = (r_retry < RETRY_MAX);

  // State register: reset returns to the power-up wait and abandons any open transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= PWR_WAIT;
    else     r_state <= w_next;
  end

  // Next-state decode and one-cycle datapath strobes.
  always_comb begin
    w_next        = r_state;
    w_latch       = 1'b0;
    w_retry_inc   = 1'b0;
    w_cnt_restart = 1'b0;
    w_idx_inc     = 1'b0;
    w_idx_clr     = 1'b0;
    w_set_fail    = 1'b0;
    w_clr_fail    = 1'b0;
    case (r_state)
      PWR_WAIT: if (STARTUP_MS == 0 || w_start_hit) w_next = FETCH;
      FETCH: begin
        w_latch = 1'b1;
        if (bus.tbl_reg == 8'hFF) begin
          w_next        = DELAY;
          w_cnt_restart = 1'b1;
        end else begin
          w_next = ISSUE;
        end
      end
      ISSUE: w_next = WAIT_WR;
      WAIT_WR: begin
        if (bus.i2c_done) begin
          if (!bus.i2c_error) begin
`ifdef I2C_INIT_READBACK_EN
            w_next = ISSUE_RD;
`else
            w_next = NEXT;
`endif
          end else if (w_can_retry) begin
            w_retry_inc = 1'b1;
            w_next      = ISSUE;
          end else begin
            w_set_fail = 1'b1;
            w_next     = FAIL;
          end
        end
      end
`ifdef I2C_INIT_READBACK_EN
      ISSUE_RD: w_next = WAIT_RD;
      WAIT_RD: begin
        if (bus.i2c_done) begin
          if (!bus.i2c_error && (bus.i2c_rdata == r_data)) begin
            w_next = NEXT;
          end else if (w_can_retry) begin
            w_retry_inc = 1'b1;
            w_next      = ISSUE;
          end else begin
            w_set_fail = 1'b1;
            w_next     = FAIL;
          end
        end
      end
`endif
      DELAY: if (r_data == 8'd0 || w_delay_hit) w_next = NEXT;
      NEXT: begin
        if (r_idx == LAST_IDX) begin
          w_next = DONE;
        end else begin
          w_idx_inc = 1'b1;
          w_next    = FETCH;
        end
      end
      DONE, FAIL: begin
        if (bus.init_start) begin
          w_clr_fail = 1'b1;
          w_idx_clr  = 1'b1;
          w_next     = FETCH;
        end
      end
      default: w_next = PWR_WAIT;
    endcase
  end

  // Table index, latched entry, retry count, failing index and ms timebase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= 8'd0;
      r_reg      <= 8'd0;
      r_data     <= 8'd0;
      r_retry    <= 8'd0;
      r_cyc      <= 32'd0;
      r_ms       <= 16'd0;
      r_fail_idx <= 8'd0;
    end else begin
      if (w_idx_clr)      r_idx <= 8'd0;
      else if (w_idx_inc) r_idx <= r_idx + 8'd1;

      if (w_latch) begin
        r_reg   <= bus.tbl_reg;
        r_data  <= bus.tbl_data;
        r_retry <= 8'd0;
      end else if (w_retry_inc) begin
        r_retry <= r_retry + 8'd1;
      end

      if (w_set_fail)      r_fail_idx <= r_idx;
      else if (w_clr_fail) r_fail_idx <= 8'd0;

      if (w_cnt_restart) begin
        r_cyc <= 32'd0;
        r_ms  <= 16'd0;
      end else if (r_state == PWR_WAIT || r_state == DELAY) begin
        if (w_tick) begin
          r_cyc <= 32'd0;
          r_ms  <= r_ms + 16'd1;
        end else begin
          r_cyc <= r_cyc + 32'd1;
        end
      end
    end
  end

`ifdef I2C_INIT_READBACK_EN
  logic r_rw;

  // Direction flag: set for the read-back request and cleared for each write, held between.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_rw <= 1'b0;
    else if (w_next == ISSUE_RD) r_rw <= 1'b1;
    else if (w_next == ISSUE)    r_rw <= 1'b0;
  end

  assign bus.i2c_rw    = r_rw;
  assign bus.i2c_start = (r_state == ISSUE) || (r_state == ISSUE_RD);
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^bus.i2c_rdata;
  assign bus.i2c_rw     = 1'b0;
  assign bus.i2c_start  = (r_state == ISSUE);
`endif

  assign bus.tbl_idx        = r_idx;
  assign bus.i2c_slave_addr = SLAVE_ADDR;
  assign bus.i2c_reg_addr   = r_reg;
  assign bus.i2c_wdata      = r_data;
  assign bus.busy           = !((r_state == DONE) || (r_state == FAIL));
  assign bus.init_done      = (r_state == DONE);
  assign bus.init_fail      = (r_state == FAIL);
  assign bus.fail_idx       = r_fail_idx;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// tb_i2c_init_sequencer
// Directed bench with a scoreboard of expected I2C transactions. Each expected
// transaction also carries the response the master model must return.
// The table has five entries: three writes, a 10 ms delay, then a final write.
module tb_i2c_init_sequencer;
  localparam int N       = 5;
  localparam int STARTUP = 5;
`ifdef I2C_INIT_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  typedef struct {
    int         idx;
    logic [7:0] ra;
    logic [7:0] wd;
    logic       rw;
    logic       err;
    logic [7:0] rd;
  } txn_t;

  txn_t exp_q[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:0] t_reg  [256];
  logic [7:0] t_data [256];
  int starts;
  int idx_starts [256];
  int first_cyc;
  int gap_e4;
  int last_done_cyc = 0;

  i2c_init_sequencer_if bus();

  i2c_init_sequencer #(
    .CLK_FREQ_HZ(1000),
    .SLAVE_ADDR (7'h39),
    .NUM_ENTRIES(N),
    .STARTUP_MS (STARTUP),
    .MAX_RETRIES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always_comb begin
    bus.tbl_reg  = t_reg[bus.tbl_idx];
    bus.tbl_data = t_data[bus.tbl_idx];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic rw, input logic err, input logic [7:0] rd);
    txn_t t;
    t.idx = i; t.ra = t_reg[i]; t.wd = t_data[i];
    t.rw = rw; t.err = err; t.rd = rd;
    exp_q.push_back(t);
  endtask

  task automatic push_entry(input int i, input int nacks);
    for (int k = 0; k < nacks; k++) push(i, 1'b0, 1'b1, 8'h00);
    push(i, 1'b0, 1'b0, 8'h00);
`ifdef I2C_INIT_READBACK_EN
    push(i, 1'b1, 1'b0, t_data[i]);
`endif
  endtask

  task automatic clr_stats();
    starts = 0; first_cyc = -1; gap_e4 = -1;
    for (int k = 0; k < 256; k++) idx_starts[k] = 0;
  endtask

  task automatic pulse_start(output int p);
    @(negedge clk); p = cyc; bus.init_start = 1'b1;
    @(negedge clk); bus.init_start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int k = 0;
    while (!(bus.init_done || bus.init_fail) && k < 2000) begin
      @(negedge clk); k++;
    end
    chk({tag, "_timeout"}, 32'(k < 2000), 32'(1));
  endtask

  // I2C master model: answers each request two cycles later with the scoreboard's response.
  initial begin : master
    txn_t        cur;
    int          pend;
    logic        drv;
    logic [16:0] snap;
    pend = 0; drv = 1'b0; snap = '0;
    cur.idx = 0; cur.ra = 0; cur.wd = 0; cur.rw = 0; cur.err = 0; cur.rd = 0;
    bus.i2c_done = 1'b0; bus.i2c_error = 1'b0; bus.i2c_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (drv) begin
        bus.i2c_done = 1'b0; bus.i2c_error = 1'b0; drv = 1'b0;
      end
      if (rst) begin
        pend = 0;
      end else if (pend > 0) begin
        if (pend == 2) chk("start_one_cycle", 32'(bus.i2c_start), 32'(0));
        pend--;
        if (pend == 0) begin
          chk("hold_stable", 32'({bus.i2c_reg_addr, bus.i2c_wdata, bus.i2c_rw}), 32'(snap));
          bus.i2c_done = 1'b1; bus.i2c_error = cur.err; bus.i2c_rdata = cur.rd;
          drv = 1'b1; last_done_cyc = cyc;
        end
      end else if (bus.i2c_start) begin
        starts++;
        idx_starts[bus.tbl_idx]++;
        if (first_cyc < 0) first_cyc = cyc;
        if (bus.tbl_idx == 8'd4 && !bus.i2c_rw && gap_e4 < 0) gap_e4 = cyc - last_done_cyc;
        snap = {bus.i2c_reg_addr, bus.i2c_wdata, bus.i2c_rw};
        chk("sb_extra_start", 32'(exp_q.size() > 0), 32'(1));
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          chk("txn_idx",   32'(bus.tbl_idx),      32'(cur.idx));
          chk("txn_reg",   32'(bus.i2c_reg_addr), 32'(cur.ra));
          chk("txn_wdata", 32'(bus.i2c_wdata),    32'(cur.wd));
          chk("txn_rw",    32'(bus.i2c_rw),       32'(cur.rw));
        end else begin
          cur.err = 1'b0; cur.rd = 8'h00;
        end
        pend = 2;
      end
    end
  end

  initial begin : stim
    int p;
    bus.init_start = 1'b0;
    for (int k = 0; k < 256; k++) begin t_reg[k] = 8'h00; t_data[k] = 8'h00; end
    t_reg[0] = 8'h10; t_data[0] = 8'h11;
    t_reg[1] = 8'h20; t_data[1] = 8'h22;
    t_reg[2] = 8'h30; t_data[2] = 8'h33;
    t_reg[3] = 8'hFF; t_data[3] = 8'd10;
    t_reg[4] = 8'h40; t_data[4] = 8'hA5;
    clr_stats();

    // Reset state
    #12;
    chk("rst_busy",      32'(bus.busy),           32'(1));
    chk("rst_init_done", 32'(bus.init_done),      32'(0));
    chk("rst_init_fail", 32'(bus.init_fail),      32'(0));
    chk("rst_fail_idx",  32'(bus.fail_idx),       32'(0));
    chk("rst_tbl_idx",   32'(bus.tbl_idx),        32'(0));
    chk("rst_start",     32'(bus.i2c_start),      32'(0));
    chk("rst_rw",        32'(bus.i2c_rw),         32'(0));
    chk("rst_reg_addr",  32'(bus.i2c_reg_addr),   32'(0));
    chk("rst_wdata",     32'(bus.i2c_wdata),      32'(0));
    chk("slave_addr",    32'(bus.i2c_slave_addr), 32'(7'h39));

    // Run 1: power-up wait, all writes ACKed, delay entry between entries 2 and 4
    push_entry(0, 0); push_entry(1, 0); push_entry(2, 0); push_entry(4, 0);
    @(negedge clk); rst = 1'b0;
    wait_end("run1");
    chk("run1_done",        32'(bus.init_done),   32'(1));
    chk("run1_fail",        32'(bus.init_fail),   32'(0));
    chk("run1_busy",        32'(bus.busy),        32'(0));
    chk("run1_first_start", 32'(first_cyc + 1),   32'(STARTUP + 2));
    chk("run1_starts",      32'(starts),          32'(4 * (1 + RB)));
    chk("run1_q_empty",     32'(exp_q.size()),    32'(0));
    chk("run1_delay_gap",   32'(gap_e4 >= 10),    32'(1));

    // Run 2: rerun without startup wait; entry 1 NACKs twice; a busy init_start is ignored
    clr_stats();
    push_entry(0, 0); push_entry(1, 2); push_entry(2, 0); push_entry(4, 0);
    pulse_start(p);
    repeat (3) @(negedge clk);
    chk("run2_busy", 32'(bus.busy), 32'(1));
    bus.init_start = 1'b1;
    @(negedge clk); bus.init_start = 1'b0;
    wait_end("run2");
    chk("run2_done",        32'(bus.init_done),  32'(1));
    chk("run2_first_start", 32'(first_cyc),      32'(p + 2));
    chk("run2_e1_starts",   32'(idx_starts[1]),  32'(3 + RB));
    chk("run2_q_empty",     32'(exp_q.size()),   32'(0));

    // Run 3: entry 2 always NACKs -> abort after 1+MAX_RETRIES attempts
    clr_stats();
    push_entry(0, 0); push_entry(1, 0);
    for (int k = 0; k < 4; k++) push(2, 1'b0, 1'b1, 8'h00);
    pulse_start(p);
    wait_end("run3");
    chk("run3_fail",      32'(bus.init_fail),                  32'(1));
    chk("run3_done",      32'(bus.init_done),                  32'(0));
    chk("run3_busy",      32'(bus.busy),                       32'(0));
    chk("run3_fail_idx",  32'(bus.fail_idx),                   32'(2));
    chk("run3_e2_starts", 32'(idx_starts[2]),                  32'(4));
    repeat (20) @(negedge clk);
    chk("run3_no_e3_e4",  32'(idx_starts[3] + idx_starts[4]),  32'(0));
    chk("run3_starts",    32'(starts),                         32'(2 * (1 + RB) + 4));
    chk("run3_q_empty",   32'(exp_q.size()),                   32'(0));

    // Stray completion while idle must not disturb the aborted state
    bus.i2c_done = 1'b1;
    @(negedge clk); bus.i2c_done = 1'b0;
    @(negedge clk);
    chk("stray_done_fail", 32'(bus.init_fail), 32'(1));
    chk("stray_done_idx",  32'(bus.fail_idx),  32'(2));

    // Run 4: restart from FAIL clears the flags and completes
    clr_stats();
    push_entry(0, 0); push_entry(1, 0); push_entry(2, 0);
`ifdef I2C_INIT_READBACK_EN
    push(4, 1'b0, 1'b0, 8'h00);
    push(4, 1'b1, 1'b0, 8'h00);
    push(4, 1'b0, 1'b0, 8'h00);
    push(4, 1'b1, 1'b0, 8'hA5);
`else
    push_entry(4, 0);
`endif
    pulse_start(p);
    chk("run4_fail_clr",  32'(bus.init_fail), 32'(0));
    chk("run4_idx_clr",   32'(bus.fail_idx),  32'(0));
    chk("run4_busy",      32'(bus.busy),      32'(1));
    wait_end("run4");
    chk("run4_done",      32'(bus.init_done), 32'(1));
    chk("run4_starts",    32'(starts),        32'(4 + RB * 6));
    chk("run4_q_empty",   32'(exp_q.size()),  32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
